rom_arbiter_rr_pipe: RTL
========================

Name: rom_arbiter_rr_pipe

Overview:
N-port read arbiter in front of a shared single-port ROM/RAM read port; successor of the fixed 4-port preemptive ROM arbiter.
- Generalised port count.
- Per-port preempt bits.
- Round-robin fairness among normal requesters.
- Tracked read-data return: each read gets a per-port data-valid strobe after a fixed memory latency.
- Sits between baseband consumers (correlator/acquisition engines) and the ROM macro.

Parameters:
NUM_PORTS, 4, number of requesting ports (2..16)
ADDR_WIDTH, 10, memory address width
DATA_WIDTH, 32, memory data width
READ_LATENCY, 1, cycles from accepted request to mem_d4rd valid (1..8)
STARVE_LIMIT, 15, wait cycles before a normal request is promoted (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rd  in  NUM_PORTS  per-port read request, held until accepted
preempt  in  NUM_PORTS  per-port high-priority qualifier, meaningful only with rd
addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
accept  out  NUM_PORTS  one-hot grant, combinational, same cycle as request
data_valid  out  NUM_PORTS  one-hot, data on data belongs to this port
data  out  DATA_WIDTH  read data, direct pass-through of mem_d4rd
mem_rd  out  1  memory read strobe
mem_addr  out  ADDR_WIDTH  address of the winning port
mem_accept  in  1  memory takes request this cycle
mem_d4rd  in  DATA_WIDTH  memory read data

Behaviour:
- Reset values:
  - rr_ptr = 0.
  - Tag pipeline all invalid.
  - data_valid = 0.
  - accept = 0 (rd low in reset).
- mem_rd = OR of rd. mem_addr = winner's addr; 0 when no rd.
- Winner selection, combinational, each cycle:
  - Class A: ports with rd & preempt. Lowest index wins.
  - Class B, only when class A is empty: round-robin among rd ports. Search starts at rr_ptr, wraps modulo NUM_PORTS.
- accept[winner] = mem_accept & |rd. All other bits are 0. accept is never multi-hot.
- rr_ptr update on an accepted class-B grant to port k: rr_ptr <= (k+1) mod NUM_PORTS. Class-A grants and non-accepted cycles leave rr_ptr unchanged.
- Tag pipeline:
  - READ_LATENCY stages of {valid, port index (clog2(NUM_PORTS) bits)}.
  - Stage 0 loads {1, winner} on an accepted grant, else {0, x}.
  - Shifts every cycle, no stall.
  - data_valid = onehot(last stage index) when last stage valid.
  - Net effect: a grant at cycle t gives data_valid at cycle t+READ_LATENCY.
- Back-to-back grants, one per cycle, each return in order on successive cycles. There is no throughput limit.
- A requester must keep rd and addr stable until accept. The arbiter may switch winner between cycles while mem_accept = 0 (preempt arrival re-evaluates).
- NUM_PORTS = 1: grant is rd & mem_accept; rr_ptr is constant 0.
- Reset mid-operation: in-flight tags are discarded. No data_valid for reads already issued.

Optional Feature:
Macro ROM_ARB_STARVE_GUARD_EN.
- Defined:
  - Per-port wait counter, clog2(STARVE_LIMIT+1) bits.
  - Increments, saturating, while rd[i] & !accept[i].
  - Clears on accept[i] or rd[i] = 0.
  - When the counter reaches STARVE_LIMIT, port i joins class A regardless of preempt. This bounds waiting under continuous preempt traffic.
  - Counters reset to 0.
- Undefined: no counters; STARVE_LIMIT is ignored; class A = rd & preempt only.

Decomposition:
- Package rom_arb_pkg:
  - clog2 helper function.
  - Port-index width constant derivation.
  - onehot-from-index function.
  - Tag struct {valid, idx}.
- One sub-module: rr_priority_pick (NUM_PORTS), combinational.
  - Inputs: request vector, start pointer.
  - Outputs: found, index, one-hot.
  - Instantiated twice: class A with pointer 0, class B with rr_ptr.

Test Plan:
- Round-robin: NUM_PORTS=4, rd=4'b1111, preempt=0, mem_accept=1 for 8 cycles.
  - Required: accept sequence 0,1,2,3,0,1,2,3.
  - Required: data_valid is the same sequence delayed READ_LATENCY=2 cycles.
  - Required: data equals mem_d4rd.
- Preempt: rd=4'b1111, preempt=4'b0100.
  - Required: port 2 accepted every cycle; rr_ptr unchanged.
  - Required: after preempt=0, round-robin resumes from the pre-preempt pointer.
- Stall: mem_accept=0 for 3 cycles with rd=4'b0011, addr1=0x155.
  - Required: accept=0, mem_rd=1, no data_valid.
  - Required: mem_addr follows rr winner; first grant goes to port 0 (rr_ptr=0), then port 1 with mem_addr=0x155.
- Reset mid-flight: grant at cycle t, rst high at t+1 with READ_LATENCY=3.
  - Required: data_valid stays 0 through t+5; rr_ptr=0 after release.
- Starvation (ROM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=3): rd=4'b0011, preempt=4'b0001 continuously.
  - Required: port 1 accepted on the 4th cycle of waiting, its counter cleared, then port 0 again.
  - Required: without the macro, port 1 is never accepted.
- Idle: rd=0.
  - Required: mem_rd=0, mem_addr=0, accept=0, data_valid=0.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the round-robin ROM read arbiter.
package rom_arb_pkg;

  localparam int unsigned MAX_PORTS = 16;
  localparam int unsigned MAX_IDX_W = 4;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Index width never drops below one bit, so single-port builds stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

  function automatic logic [MAX_PORTS-1:0] onehot_idx(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_PORTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority pick: first set request at or after start, wrapping.
module rr_priority_pick
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  localparam int unsigned IDX_W = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic                 found,
  output logic [IDX_W-1:0]     idx,
  output logic [NUM_PORTS-1:0] onehot
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    pos    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      pos = IDX_W'((32'(start) + i) % NUM_PORTS);
      if (!found && req[pos]) begin
        found       = 1'b1;
        idx         = pos;
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_arbiter_rr_pipe.sv
// N-port preempt/round-robin read arbiter with tracked read-data return.
// Optional starvation guard: define ROM_ARB_STARVE_GUARD_EN.
module rom_arbiter_rr_pipe
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            rd,
  input  logic [NUM_PORTS-1:0]            preempt,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  output logic [NUM_PORTS-1:0]            accept,
  output logic [NUM_PORTS-1:0]            data_valid,
  output logic [DATA_WIDTH-1:0]           data,
  output logic                            mem_rd,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic                            mem_accept,
  input  logic [DATA_WIDTH-1:0]           mem_d4rd
);

  localparam int unsigned IDX_W = idx_width(NUM_PORTS);

  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_PORTS-1:0] class_a_req;
  logic                 a_found, b_found;
  logic [IDX_W-1:0]     a_idx, b_idx, winner;
  logic [NUM_PORTS-1:0] a_oh, b_oh;
  logic                 any_rd, grant;
  tag_t                 tag_pipe [READ_LATENCY];

`ifdef ROM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = idx_width(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]     wait_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] starved;

  always_comb begin
    starved = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++)
      starved[i] = rd[i] && (wait_cnt[i] >= CNT_W'(STARVE_LIMIT));
  end

  // Starved ports outrank plain preempt traffic, otherwise the wait bound would not hold.
  assign class_a_req = (|starved) ? starved : (rd & preempt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) wait_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (accept[i] || !rd[i])
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] < CNT_W'(STARVE_LIMIT))
          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
      end
    end
  end
`else
  assign class_a_req = rd & preempt;
`endif

  rr_priority_pick #(.NUM_PORTS(NUM_PORTS)) u_pick_a (
    .req    (class_a_req),
    .start  ('0),
    .found  (a_found),
    .idx    (a_idx),
    .onehot (a_oh)
  );

  rr_priority_pick #(.NUM_PORTS(NUM_PORTS)) u_pick_b (
    .req    (rd),
    .start  (rr_ptr),
    .found  (b_found),
    .idx    (b_idx),
    .onehot (b_oh)
  );

  assign any_rd   = |rd;
  assign grant    = mem_accept && any_rd;
  assign winner   = a_found ? a_idx : b_idx;
  assign accept   = grant ? (a_found ? a_oh : b_oh) : '0;
  assign mem_rd   = any_rd;
  assign mem_addr = any_rd ? addr[32'(winner)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign data     = mem_d4rd;

  // Pointer advances past the winner only on accepted round-robin grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (grant && !a_found)
      rr_ptr <= (b_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : b_idx + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: grant, idx: MAX_IDX_W'(winner)};
      for (int unsigned i = 1; i < READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign data_valid = tag_pipe[READ_LATENCY-1].valid
                    ? NUM_PORTS'(onehot_idx(tag_pipe[READ_LATENCY-1].idx)) : '0;

endmodule
